interrupt_arbiter: RTL and testbench
====================================

Name: interrupt_arbiter

Overview:
- Collects one-cycle interrupt request pulses from VBlank, LCD STAT, timer (TIMA overflow), serial and joypad, latches them into IF (0xFF0F), and masks them with IE (0xFFFF) and the master enable IME.
- Picks the highest-priority pending source and presents its restart vector to the CPU control unit, at instruction boundaries only.
- Runs a req/ack dispatch handshake, then clears the serviced IF bit and IME.
- Sits between the peripheral blocks (timers, video, serial, pad) and the z80-style core.

Parameters:
- NUM_SRC, 5, number of interrupt sources; bit i has vector 0x40 + 8*i; bit 0 has the highest priority.
- ACK_TIMEOUT, 15, cycles to wait in REQ for iIntAck before returning to IDLE without clearing IF; range 1..255.

Ports:
- iClock  in  1  system clock
- iReset_n  in  1  asynchronous active-low reset
- iIrq  in  NUM_SRC  request pulses: [0] VBlank, [1] STAT, [2] timer, [3] serial, [4] joypad
- iIfWe  in  1  CPU write strobe for IF
- iIeWe  in  1  CPU write strobe for IE
- iWrData  in  8  CPU write data
- iEi  in  1  EI executed (one-cycle pulse)
- iDi  in  1  DI executed (one-cycle pulse)
- iReti  in  1  RETI executed (one-cycle pulse)
- iEof  in  1  end-of-instruction (boundary) pulse
- iIntAck  in  1  core has accepted the dispatch
- oIf  out  8  IF readback; bits 7:5 read 1
- oIe  out  8  IE readback, full 8 bits
- oIme  out  1  master enable
- oIntReq  out  1  dispatch request to the core
- oVector  out  8  restart address low byte
- oWake  out  1  (IRQ_HALT_WAKE_EN only) halt wake

Behaviour:
- Reset (asynchronous, active-low):
  - IF = 0, IE = 0, IME = 0.
  - oIntReq = 0, oVector = 0x00, oWake = 0, FSM in IDLE, EI-delay flag = 0.
- IF update, every cycle: IF_next = (iIfWe ? iWrData[4:0] : IF) | iIrq.
  - A hardware set wins over a CPU write of 0 in the same cycle.
  - The serviced-bit clear on ack is applied before the OR, so a new pulse on the same bit in the ack cycle stays latched.
- IE: iIeWe loads all 8 bits; only bits [NUM_SRC-1:0] participate in arbitration.
- Pending = IF & IE[NUM_SRC-1:0]. Winner = lowest set index (fixed priority).
- IME rules:
  - iDi clears IME immediately and also cancels a pending EI delay.
  - iReti sets IME on the next edge.
  - iEi arms a delay flag; IME becomes 1 on the first iEof after the iEi cycle, so the instruction following EI completes uninterrupted.
  - iEi and iDi in the same cycle: DI wins.
- FSM states:
  - IDLE:
    - Leave when iEof & IME & |Pending.
    - On leaving, latch the winner index and set oVector = 0x40 + 8*idx.
    - Go to REQ.
  - REQ:
    - oIntReq = 1; oVector is held stable and does not change if a higher-priority source arrives.
    - On iIntAck go to ACK.
    - If the timeout counter reaches ACK_TIMEOUT, return to IDLE; IF and IME are untouched.
  - ACK, one cycle:
    - Clear the latched IF bit and clear IME.
    - oIntReq = 0.
    - Go to IDLE.
- Same-cycle events:
  - iIntAck is ignored outside REQ.
  - iDi while in REQ does not withdraw the request; the dispatch already committed.
  - A CPU write to IE that masks the latched source while in REQ also does not withdraw the request.
- Latency: a request pulse is visible in oIf the next cycle. oIntReq rises one cycle after the qualifying iEof.
- Reset asserted mid-dispatch forces IDLE immediately and drops oIntReq asynchronously.

Optional Feature:
- IRQ_HALT_WAKE_EN defined:
  - oWake = |(IF & IE[NUM_SRC-1:0]), registered.
  - oWake is asserted regardless of IME, so the core leaves HALT even with IME = 0.
- IRQ_HALT_WAKE_EN undefined: oWake is tied to 0 and its logic is not synthesised.

Decomposition:
- Shared package/include (alongside the existing definitions header):
  - Source-index constants IRQ_VBLANK..IRQ_JOYPAD.
  - Vector constants 0x40/0x48/0x50/0x58/0x60.
  - FSM state encodings IRQ_IDLE, IRQ_REQ, IRQ_ACK.
- One natural sub-module, irq_priority_enc: combinational fixed-priority encoder producing the winner index and a valid bit from the pending vector, reusable by other arbiters.

Test Plan:
- Timer pulse with IE=0x04, IME=1 -> IF=0xE4 the next cycle. iEof -> oIntReq=1, oVector=0x50. Ack -> IF=0xE0, IME=0.
- iIrq=0x05 in the same cycle, IE=0x1F, IME=1 -> oVector=0x40 (VBlank). After its ack, RETI, then iEof -> second dispatch with oVector=0x50.
- iEi, then iEof #1 -> IME=1 after that edge and no dispatch at iEof #1. Next iEof -> oIntReq=1.
- Timeout: REQ with no ack for 15 cycles -> oIntReq=0, IF bit still set, IME=1, re-request at the next iEof.
- iIfWe with data 0x00 in the same cycle as iIrq[2] -> IF=0xE4. Assert iReset_n low while in REQ -> oIntReq=0 immediately, IF=0xE0, IE=0x00.
- IRQ_HALT_WAKE_EN defined with IME=0, IE=0x10, joypad pulse -> oWake=1 two cycles after the pulse and oIntReq stays 0.

Source files
------------

// File: rtl/interrupt_arbiter_pkg.sv
// rtl/interrupt_arbiter_pkg.sv - shared interrupt source indices, vectors and dispatch FSM encodings
package interrupt_arbiter_pkg;

    localparam int IRQ_VBLANK = 0;
    localparam int IRQ_STAT   = 1;
    localparam int IRQ_TIMER  = 2;
    localparam int IRQ_SERIAL = 3;
    localparam int IRQ_JOYPAD = 4;

    localparam logic [7:0] IRQ_VEC_VBLANK = 8'h40;
    localparam logic [7:0] IRQ_VEC_STAT   = 8'h48;
    localparam logic [7:0] IRQ_VEC_TIMER  = 8'h50;
    localparam logic [7:0] IRQ_VEC_SERIAL = 8'h58;
    localparam logic [7:0] IRQ_VEC_JOYPAD = 8'h60;

    typedef enum logic [1:0] {
        IRQ_IDLE = 2'd0,
        IRQ_REQ  = 2'd1,
        IRQ_ACK  = 2'd2
    } irq_state_t;

    // Restart address low byte for a source index: 0x40 + 8*idx.
    function automatic logic [7:0] irq_vector(input logic [4:0] idx);
        return 8'h40 + {idx, 3'b000};
    endfunction

endpackage

// File: rtl/irq_priority_enc.sv
// rtl/irq_priority_enc.sv - fixed-priority encoder, lowest set index wins
module irq_priority_enc #(
    parameter int N     = 5,
    parameter int IDX_W = 3
) (
    input  logic [N-1:0]     i_pending,
    output logic [IDX_W-1:0] o_idx,
    output logic             o_valid
);

    // Scan high to low so the last assignment is the lowest set bit.
    always_comb begin
        o_idx   = '0;
        o_valid = 1'b0;
        for (int i = N - 1; i >= 0; i--) begin
            if (i_pending[i]) begin
                o_idx   = IDX_W'(i);
                o_valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/interrupt_arbiter.sv
// rtl/interrupt_arbiter.sv - IF/IE/IME interrupt arbiter with req/ack dispatch to the core
// Optional halt wake output enabled by defining IRQ_HALT_WAKE_EN.
module interrupt_arbiter
    import interrupt_arbiter_pkg::*;
#(
    parameter int NUM_SRC     = 5,
    parameter int ACK_TIMEOUT = 15
) (
    input  logic               iClock,
    input  logic               iReset_n,
    input  logic [NUM_SRC-1:0] iIrq,
    input  logic               iIfWe,
    input  logic               iIeWe,
    input  logic [7:0]         iWrData,
    input  logic               iEi,
    input  logic               iDi,
    input  logic               iReti,
    input  logic               iEof,
    input  logic               iIntAck,
    output logic [7:0]         oIf,
    output logic [7:0]         oIe,
    output logic               oIme,
    output logic               oIntReq,
    output logic [7:0]         oVector,
    output logic               oWake
);

    localparam int IDX_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

    irq_state_t         r_state, w_state_next;
    logic [NUM_SRC-1:0] r_if, w_if_next, w_pending, w_clr_mask;
    logic [7:0]         r_ie, r_vector, r_cnt;
    logic               r_ime, r_ei_pend;
    logic [IDX_W-1:0]   r_idx, w_win_idx;
    logic               w_win_valid;

    assign w_pending = r_if & r_ie[NUM_SRC-1:0];

    irq_priority_enc #(.N(NUM_SRC), .IDX_W(IDX_W)) u_prio (
        .i_pending (w_pending),
        .o_idx     (w_win_idx),
        .o_valid   (w_win_valid)
    );

    // Serviced-bit clear is applied before the OR so a same-cycle pulse survives.
    assign w_clr_mask = (r_state == IRQ_ACK) ? (NUM_SRC'(1) << r_idx) : '0;
    assign w_if_next  = ((iIfWe ? iWrData[NUM_SRC-1:0] : r_if) & ~w_clr_mask) | iIrq;

    always_ff @(posedge iClock or negedge iReset_n) begin
        if (!iReset_n) begin
            r_if      <= '0;
            r_ie      <= '0;
            r_ime     <= 1'b0;
            r_ei_pend <= 1'b0;
        end else begin
            r_if <= w_if_next;
            if (iIeWe)
                r_ie <= iWrData;
            if (iDi) begin
                r_ime     <= 1'b0;
                r_ei_pend <= 1'b0;
            end else begin
                if (r_state == IRQ_ACK)
                    r_ime <= 1'b0;
                else if (iReti || (r_ei_pend && iEof))
                    r_ime <= 1'b1;
                // EI arms the flag; only an iEof in a later cycle consumes it.
                if (iEi)
                    r_ei_pend <= 1'b1;
                else if (iEof)
                    r_ei_pend <= 1'b0;
            end
        end
    end

    always_ff @(posedge iClock or negedge iReset_n) begin
        if (!iReset_n)
            r_state <= IRQ_IDLE;
        else
            r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IRQ_IDLE: if (iEof && r_ime && w_win_valid) w_state_next = IRQ_REQ;
            IRQ_REQ: begin
                if (iIntAck)
                    w_state_next = IRQ_ACK;
                else if (r_cnt == 8'(ACK_TIMEOUT - 1))
                    w_state_next = IRQ_IDLE;
            end
            IRQ_ACK:  w_state_next = IRQ_IDLE;
            default:  w_state_next = IRQ_IDLE;
        endcase
    end

    always_comb begin
        oIntReq = (r_state == IRQ_REQ);
    end

    always_ff @(posedge iClock or negedge iReset_n) begin
        if (!iReset_n) begin
            r_cnt    <= '0;
            r_idx    <= '0;
            r_vector <= '0;
        end else begin
            if (r_state == IRQ_REQ && w_state_next == IRQ_REQ)
                r_cnt <= r_cnt + 8'd1;
            else
                r_cnt <= '0;
            if (r_state == IRQ_IDLE && w_state_next == IRQ_REQ) begin
                r_idx    <= w_win_idx;
                r_vector <= irq_vector(5'(w_win_idx));
            end
        end
    end

`ifdef IRQ_HALT_WAKE_EN
    logic r_wake;
    always_ff @(posedge iClock or negedge iReset_n) begin
        if (!iReset_n)
            r_wake <= 1'b0;
        else
            r_wake <= |w_pending;
    end
    assign oWake = r_wake;
`else
    assign oWake = 1'b0;
`endif

    assign oIf     = {{(8 - NUM_SRC){1'b1}}, r_if};
    assign oIe     = r_ie;
    assign oIme    = r_ime;
    assign oVector = r_vector;

endmodule

// File: tb/tb_interrupt_arbiter.sv
// tb/tb_interrupt_arbiter.sv - directed self-checking bench for interrupt_arbiter
module tb_interrupt_arbiter;

    logic       iClock = 1'b0;
    logic       iReset_n;
    logic [4:0] iIrq;
    logic       iIfWe, iIeWe, iEi, iDi, iReti, iEof, iIntAck;
    logic [7:0] iWrData;
    logic [7:0] oIf, oIe, oVector;
    logic       oIme, oIntReq, oWake;

    int n_checks = 0;
    int n_fail   = 0;

    interrupt_arbiter dut (
        .iClock   (iClock),
        .iReset_n (iReset_n),
        .iIrq     (iIrq),
        .iIfWe    (iIfWe),
        .iIeWe    (iIeWe),
        .iWrData  (iWrData),
        .iEi      (iEi),
        .iDi      (iDi),
        .iReti    (iReti),
        .iEof     (iEof),
        .iIntAck  (iIntAck),
        .oIf      (oIf),
        .oIe      (oIe),
        .oIme     (oIme),
        .oIntReq  (oIntReq),
        .oVector  (oVector),
        .oWake    (oWake)
    );

    always #5 iClock = ~iClock;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge iClock);
        #1;
    endtask

    task automatic pulse_irq(input logic [4:0] v);
        iIrq = v; step(); iIrq = '0;
    endtask

    task automatic write_ie(input logic [7:0] v);
        iIeWe = 1'b1; iWrData = v; step(); iIeWe = 1'b0; iWrData = '0;
    endtask

    task automatic do_reti();
        iReti = 1'b1; step(); iReti = 1'b0;
    endtask

    task automatic do_eof();
        iEof = 1'b1; step(); iEof = 1'b0;
    endtask

    task automatic do_ack();
        iIntAck = 1'b1; step(); iIntAck = 1'b0; step();
    endtask

    initial begin
        iReset_n = 1'b0;
        iIrq = '0; iIfWe = 0; iIeWe = 0; iWrData = '0;
        iEi = 0; iDi = 0; iReti = 0; iEof = 0; iIntAck = 0;
        step(); step();
        iReset_n = 1'b1;
        step();

        check_eq("rst_if",     oIf,     8'hE0);
        check_eq("rst_ie",     oIe,     8'h00);
        check_eq("rst_ime",    oIme,    1'b0);
        check_eq("rst_req",    oIntReq, 1'b0);
        check_eq("rst_vector", oVector, 8'h00);
        check_eq("rst_wake",   oWake,   1'b0);

        // Single timer interrupt
        write_ie(8'h04);
        do_reti();
        check_eq("t1_ie",  oIe,  8'h04);
        check_eq("t1_ime", oIme, 1'b1);
        pulse_irq(5'h04);
        check_eq("t1_if", oIf, 8'hE4);
        check_eq("t1_req_before_eof", oIntReq, 1'b0);
        do_eof();
        check_eq("t1_req", oIntReq, 1'b1);
        check_eq("t1_vec", oVector, 8'h50);
        do_ack();
        check_eq("t1_if_clr",  oIf,     8'hE0);
        check_eq("t1_ime_clr", oIme,    1'b0);
        check_eq("t1_req_clr", oIntReq, 1'b0);

        // Two simultaneous sources: VBlank first, then timer
        write_ie(8'h1F);
        do_reti();
        pulse_irq(5'h05);
        check_eq("t2_if", oIf, 8'hE5);
        do_eof();
        check_eq("t2_vec0", oVector, 8'h40);
        do_ack();
        check_eq("t2_if_after_ack", oIf, 8'hE4);
        check_eq("t2_ime_after_ack", oIme, 1'b0);
        do_reti();
        do_eof();
        check_eq("t2_req1", oIntReq, 1'b1);
        check_eq("t2_vec1", oVector, 8'h50);
        pulse_irq(5'h01);
        check_eq("t2_vec_hold", oVector, 8'h50);
        check_eq("t2_req_hold", oIntReq, 1'b1);
        do_ack();
        check_eq("t2_if_final", oIf, 8'hE1);
        iIfWe = 1'b1; iWrData = 8'h00; step(); iIfWe = 1'b0;
        check_eq("t2_if_wr0", oIf, 8'hE0);

        // EI delay: first iEof only enables IME
        pulse_irq(5'h04);
        iEi = 1'b1; step(); iEi = 1'b0;
        check_eq("t3_ime_after_ei", oIme, 1'b0);
        do_eof();
        check_eq("t3_ime_eof1", oIme,    1'b1);
        check_eq("t3_req_eof1", oIntReq, 1'b0);
        do_eof();
        check_eq("t3_req_eof2", oIntReq, 1'b1);
        check_eq("t3_vec",      oVector, 8'h50);

        // Ack timeout: 15 cycles in REQ, then back to IDLE untouched
        for (int i = 0; i < 14; i++) step();
        check_eq("t4_req_last", oIntReq, 1'b1);
        step();
        check_eq("t4_req_to",  oIntReq, 1'b0);
        check_eq("t4_if_to",   oIf,     8'hE4);
        check_eq("t4_ime_to",  oIme,    1'b1);
        do_eof();
        check_eq("t4_rereq", oIntReq, 1'b1);
        do_ack();
        check_eq("t4_if_clr", oIf, 8'hE0);

        // Hardware set beats CPU write of 0; DI in REQ; async reset mid-dispatch
        iIfWe = 1'b1; iWrData = 8'h00; iIrq = 5'h04; step();
        iIfWe = 1'b0; iIrq = '0;
        check_eq("t5_if_hw_wins", oIf, 8'hE4);
        do_reti();
        do_eof();
        check_eq("t5_req", oIntReq, 1'b1);
        iDi = 1'b1; step(); iDi = 1'b0;
        check_eq("t5_req_after_di", oIntReq, 1'b1);
        check_eq("t5_ime_after_di", oIme,    1'b0);
        #2;
        iReset_n = 1'b0;
        #1;
        check_eq("t5_rst_req", oIntReq, 1'b0);
        check_eq("t5_rst_if",  oIf,     8'hE0);
        check_eq("t5_rst_ie",  oIe,     8'h00);
        step();
        iReset_n = 1'b1;
        step();

        // Halt wake with IME = 0
        write_ie(8'h10);
        pulse_irq(5'h10);
        check_eq("t6_if", oIf, 8'hF0);
        step();
`ifdef IRQ_HALT_WAKE_EN
        check_eq("t6_wake", oWake, 1'b1);
`else
        check_eq("t6_wake_off", oWake, 1'b0);
`endif
        check_eq("t6_req", oIntReq, 1'b0);
        do_eof();
        check_eq("t6_req_eof", oIntReq, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
